// File: rtl/pong_pkg.sv
// Shared types and constants for the pong paddle tracker.
// Provides default field width, length table lookup and accel constants.
package pong_pkg;

    localparam int FIELD_W_DEF = 16;

    // Acceleration: run length that doubles the step, and idle timer width.
    localparam int ACCEL_THR = 4;
    localparam int TMR_W = 8;
    localparam int RUN_W = 4;

    typedef logic signed [1:0] enc_t;

    // Paddle length for a given select; table entries come from the
    // instantiating block's parameters.
    function automatic int len_of(
        input logic [1:0] sel,
        input int l0,
        input int l1,
        input int l2,
        input int l3
    );
        int r;
        r = l0;
        unique case (sel)
            2'd0: r = l0;
            2'd1: r = l1;
            2'd2: r = l2;
            2'd3: r = l3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/quad_step.sv
// Encoder count decoder: remembers the previous count and turns the 2-bit
// wrapped difference into step_up (+1), step_dn (-1) and glitch (+/-2).
// Ports: clk, enc (current count), step_up, step_dn, glitch (comb strobes).
module quad_step
    import pong_pkg::*;
(
    input  logic clk,
    input  enc_t enc,
    output logic step_up,
    output logic step_dn,
    output logic glitch
);

    enc_t       prev;
    logic [1:0] diff;

    // prev follows the encoder every cycle, reset included.
    always_ff @(posedge clk) begin
        prev <= enc;
    end

    assign diff    = enc - prev;
    assign step_up = (diff == 2'b01);
    assign step_dn = (diff == 2'b11);
    assign glitch  = (diff == 2'b10);

endmodule

// File: rtl/paddle_track.sv
// Paddle position tracker: encoder steps move a run of LEN cells inside a
// FIELD_W-wide bitmap with saturating edges, length select and recenter.
// Ports: clk, reset (sync, high), len_sel, encoder_value, recenter,
// paddle_o, pos_o, at_min_o, at_max_o, glitch_o.
// Option: define PADDLE_TRACK_ACCEL_EN to double the step after a run of
// same-direction steps arriving close together.
module paddle_track
    import pong_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int LEN0    = 8,
    parameter int LEN1    = 4,
    parameter int LEN2    = 6,
    parameter int LEN3    = 12,
    parameter int STEP    = 1,
    localparam int POS_W  = $clog2(FIELD_W + 1)
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         len_sel,
    input  logic [1:0]         encoder_value,
    input  logic               recenter,
    output logic [FIELD_W-1:0] paddle_o,
    output logic [POS_W-1:0]   pos_o,
    output logic               at_min_o,
    output logic               at_max_o,
    output logic               glitch_o
);

    // One spare bit keeps subtraction and addition free of wrap.
    localparam int AW = POS_W + 1;
    typedef logic [AW-1:0] aw_t;

    logic step_up;
    logic step_dn;
    logic glitch;

    aw_t  pos_r;
    aw_t  len_r;
    logic glitch_r;

    aw_t  newlen;
    aw_t  maxpos;
    aw_t  cur;
    aw_t  step;
    aw_t  nxt;

    quad_step u_quad (
        .clk     (clk),
        .enc     (enc_t'(encoder_value)),
        .step_up (step_up),
        .step_dn (step_dn),
        .glitch  (glitch)
    );

`ifdef PADDLE_TRACK_ACCEL_EN
    logic [RUN_W-1:0] run_r;
    logic [TMR_W-1:0] idle_r;
    logic             dir_up_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_r    <= '0;
            idle_r   <= '0;
            dir_up_r <= 1'b0;
        end else if (recenter || glitch) begin
            run_r  <= '0;
            idle_r <= '0;
        end else if (step_up || step_dn) begin
            idle_r <= '0;
            if (run_r == '0) begin
                run_r    <= RUN_W'(1);
                dir_up_r <= step_up;
            end else if (dir_up_r == step_up) begin
                if (run_r != '1)
                    run_r <= run_r + RUN_W'(1);
            end else begin
                run_r <= '0;
            end
        end else if (idle_r == '1) begin
            // Too long since the last step: the run is over.
            run_r <= '0;
        end else begin
            idle_r <= idle_r + TMR_W'(1);
        end
    end
`endif

    always_comb begin
        newlen = aw_t'(len_of(len_sel, LEN0, LEN1, LEN2, LEN3));
        maxpos = aw_t'(FIELD_W) - newlen;
        cur    = pos_r;
        step   = aw_t'(STEP);
`ifdef PADDLE_TRACK_ACCEL_EN
        if (run_r >= RUN_W'(ACCEL_THR))
            step = aw_t'(2 * STEP);
`endif
        nxt = cur;
        if (recenter)
            nxt = maxpos >> 1;
        else if (step_up)
            nxt = (cur > step) ? cur - step : '0;
        else if (step_dn)
            // Compare against the headroom so the sum never wraps.
            nxt = (cur >= maxpos || step >= maxpos - cur)
                ? maxpos : cur + step;
        // A longer paddle near the right edge is pushed left.
        if (nxt > maxpos)
            nxt = maxpos;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_r    <= newlen;
            pos_r    <= maxpos >> 1;
            glitch_r <= 1'b0;
        end else begin
            len_r    <= newlen;
            pos_r    <= nxt;
            glitch_r <= glitch;
        end
    end

    always_comb begin
        paddle_o = '0;
        for (int i = 0; i < FIELD_W; i++)
            paddle_o[i] = (aw_t'(i) >= pos_r) && (aw_t'(i) < pos_r + len_r);
    end

    assign pos_o    = pos_r[POS_W-1:0];
    assign at_min_o = (pos_r == '0);
    assign at_max_o = (pos_r == aw_t'(FIELD_W) - len_r);
    assign glitch_o = glitch_r;

endmodule
